// File: rtl/piso_pkg.sv
// Shared definitions for the 10-bit parallel-in/serial-out transmitter:
// frame length, default idle word and transmitter state encoding.
package piso_pkg;

    localparam int FRAME_LEN = 10;

    localparam logic [FRAME_LEN-1:0] IDLE_WORD_DEF = 10'b0011111010;

    typedef enum logic {
        SYNC = 1'b0,
        RUN  = 1'b1
    } tx_state_e;

    // Even parity of a frame word, for checker modules that watch the data path.
    function automatic logic word_parity(input logic [FRAME_LEN-1:0] w);
        return ^w;
    endfunction

endpackage

// File: rtl/piso10_1_tx_fifo.sv
// Small synchronous FIFO holding words waiting for a transmit frame.
// DEPTH must be a power of two so the pointers wrap by natural overflow.
module tx_fifo
    import piso_pkg::*;
#(
    parameter int DEPTH = 2,
    parameter int WIDTH = FRAME_LEN
) (
    input  logic                         clk,
    input  logic                         rst,
    input  logic                         push,
    input  logic                         pop,
    input  logic [WIDTH-1:0]             din,
    output logic [WIDTH-1:0]             dout,
    output logic [$clog2(DEPTH+1)-1:0]   level,
    output logic                         full,
    output logic                         empty
);

    localparam int PW = $clog2(DEPTH);
    localparam int LW = $clog2(DEPTH+1);

    logic [WIDTH-1:0] r_mem [DEPTH];
    logic [PW-1:0]    r_wr_ptr;
    logic [PW-1:0]    r_rd_ptr;
    logic [LW-1:0]    r_level;
    logic             w_do_push;
    logic             w_do_pop;

    assign full      = (r_level == LW'(DEPTH));
    assign empty     = (r_level == LW'(0));
    assign level     = r_level;
    assign dout      = r_mem[r_rd_ptr];
    assign w_do_push = push && !full;
    assign w_do_pop  = pop && !empty;

    // Storage, pointers and occupancy; simultaneous push and pop keeps level.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int i = 0; i < DEPTH; i++) begin
                r_mem[i] <= '0;
            end
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_level  <= '0;
        end else begin
            if (w_do_push) begin
                r_mem[r_wr_ptr] <= din;
                r_wr_ptr        <= r_wr_ptr + PW'(1);
            end
            if (w_do_pop) begin
                r_rd_ptr <= r_rd_ptr + PW'(1);
            end
            case ({w_do_push, w_do_pop})
                2'b10:   r_level <= r_level + LW'(1);
                2'b01:   r_level <= r_level - LW'(1);
                default: r_level <= r_level;
            endcase
        end
    end

endmodule

// File: rtl/piso10_1_tx.sv
// LSB-first serializer with fixed 10-cycle frames, idle-word fill and a
// post-reset idle preamble that lets the downstream deserializer align.
module piso10_1_tx
    import piso_pkg::*;
#(
    parameter logic [FRAME_LEN-1:0] IDLE_WORD  = IDLE_WORD_DEF,
    parameter int                   DEPTH      = 2,
    parameter int                   SYNC_WORDS = 4
) (
    input  logic                        CLK_IN,
    input  logic                        RESET_IN,
    input  logic [FRAME_LEN-1:0]        DATA_IN,
    input  logic                        VALID_IN,
    output logic                        READY_OUT,
    output logic                        SERIAL_OUT,
    output logic                        FRAME_OUT,
    output logic                        IDLE_OUT,
    output logic [$clog2(DEPTH+1)-1:0]  LEVEL_OUT
);

    localparam int SCW = (SYNC_WORDS > 1) ? $clog2(SYNC_WORDS) : 1;

    logic [3:0]           r_ctr;
    logic [FRAME_LEN-1:0] r_sr;
    logic                 r_idle;
    tx_state_e            r_state;
    tx_state_e            w_state_nxt;
    logic [SCW-1:0]       r_sync_cnt;

    logic                 w_load;
    logic                 w_sync_last;
    logic                 w_data_ok;
    logic                 w_push;
    logic                 w_pop;
    logic                 w_full;
    logic                 w_empty;
    logic [FRAME_LEN-1:0] w_head;

    assign w_load      = (r_ctr == 4'(FRAME_LEN-1));
    // The last preamble word is still shifting out on this load edge, so the
    // word loaded here is already allowed to be data.
    assign w_sync_last = (r_sync_cnt == SCW'(SYNC_WORDS-1));
    assign w_data_ok   = (r_state == RUN) || w_sync_last;
    assign w_pop       = w_load && w_data_ok && !w_empty;
    assign w_push      = VALID_IN && READY_OUT;

    assign READY_OUT  = !w_full;
    assign SERIAL_OUT = r_sr[0];
    assign FRAME_OUT  = (r_ctr == 4'd0);
    assign IDLE_OUT   = r_idle;

    tx_fifo #(
        .DEPTH (DEPTH),
        .WIDTH (FRAME_LEN)
    ) u_fifo (
        .clk   (CLK_IN),
        .rst   (RESET_IN),
        .push  (w_push),
        .pop   (w_pop),
        .din   (DATA_IN),
        .dout  (w_head),
        .level (LEVEL_OUT),
        .full  (w_full),
        .empty (w_empty)
    );

    // Free-running frame phase counter, 0..FRAME_LEN-1.
    always_ff @(posedge CLK_IN or posedge RESET_IN) begin
        if (RESET_IN) begin
            r_ctr <= 4'd0;
        end else if (w_load) begin
            r_ctr <= 4'd0;
        end else begin
            r_ctr <= r_ctr + 4'd1;
        end
    end

    // Shift register and idle flag: shift right mid-frame, reload at frame end.
    always_ff @(posedge CLK_IN or posedge RESET_IN) begin
        if (RESET_IN) begin
            r_sr   <= IDLE_WORD;
            r_idle <= 1'b1;
        end else if (w_load) begin
            if (w_pop) begin
                r_sr   <= w_head;
                r_idle <= 1'b0;
            end else begin
                r_sr   <= IDLE_WORD;
                r_idle <= 1'b1;
            end
        end else begin
            r_sr   <= {1'b0, r_sr[FRAME_LEN-1:1]};
            r_idle <= r_idle;
        end
    end

    // Counts preamble words whose load edge has passed while in SYNC.
    always_ff @(posedge CLK_IN or posedge RESET_IN) begin
        if (RESET_IN) begin
            r_sync_cnt <= '0;
        end else if ((r_state == SYNC) && w_load && !w_sync_last) begin
            r_sync_cnt <= r_sync_cnt + SCW'(1);
        end else begin
            r_sync_cnt <= r_sync_cnt;
        end
    end

    // FSM state register.
    always_ff @(posedge CLK_IN or posedge RESET_IN) begin
        if (RESET_IN) begin
            r_state <= SYNC;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    // FSM next state: SYNC ends on the load edge of the last preamble word.
    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            SYNC: begin
                if (w_load && w_sync_last) begin
                    w_state_nxt = RUN;
                end else begin
                    w_state_nxt = SYNC;
                end
            end
            RUN:     w_state_nxt = RUN;
            default: w_state_nxt = SYNC;
        endcase
    end

endmodule
